// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl: match-level sequencer for two-player pong.
// Holds or serves the ball, keeps both scores and detects the winner.
// Optional pause support is compiled in when PONG_PAUSE_EN is defined.
module pong_match_ctrl #(
  parameter int WIN_SCORE    = 5,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90,
  parameter int SCORE_W      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               pause_btn,
  input  logic               miss1,
  input  logic               miss2,
  output logic               freeze,
  output logic               ball_rst,
  output logic               serve_go,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic               game_over,
  output logic               winner,
  output logic [2:0]         state
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SERVE  = 3'd1;
  localparam logic [2:0] ST_PLAY   = 3'd2;
  localparam logic [2:0] ST_POINT  = 3'd3;
  localparam logic [2:0] ST_OVER   = 3'd4;
  localparam logic [2:0] ST_PAUSED = 3'd5;

  localparam logic [SCORE_W-1:0] WIN_VAL     = SCORE_W'(WIN_SCORE);
  localparam logic [7:0]         SERVE_LAST  = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0]         POINT_LAST  = 8'(POINT_FRAMES - 1);
  localparam logic [SCORE_W-1:0] SCORE_ONE   = SCORE_W'(1);
  localparam logic [SCORE_W-1:0] SCORE_ZERO  = '0;

  logic [2:0]         state_r;
  logic [2:0]         state_nx_s;
  logic [7:0]         cnt_r;
  logic               start_q_r;
  logic               rst_q_r;
  logic               start_re_s;
  logic               pause_re_s;
  logic [SCORE_W-1:0] score1_r;
  logic [SCORE_W-1:0] score2_r;
  logic [SCORE_W-1:0] score1_nx_s;
  logic [SCORE_W-1:0] score2_nx_s;
  logic [SCORE_W-1:0] inc1_s;
  logic [SCORE_W-1:0] inc2_s;
  logic               dir_r;
  logic               dir_nx_s;
  logic               winner_r;
  logic               winner_nx_s;
  logic               serve_go_r;
  logic               freeze_s;
  logic               ball_rst_s;
  logic               game_over_s;

  // Edges are suppressed on the first cycle after reset so that a button
  // held through reset is not mistaken for a fresh press.
  assign start_re_s = start & ~start_q_r & ~rst_q_r;
  assign inc1_s     = score1_r + SCORE_ONE;
  assign inc2_s     = score2_r + SCORE_ONE;

`ifdef PONG_PAUSE_EN
  logic pause_q_r;
  assign pause_re_s = pause_btn & ~pause_q_r & ~rst_q_r;

  // Pause button history for rising-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      pause_q_r <= 1'b0;
    end else begin
      pause_q_r <= pause_btn;
    end
  end
`else
  logic unused_pause_s;
  assign unused_pause_s = pause_btn;
  assign pause_re_s     = 1'b0;
`endif

  // State, counter, score and serve registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 8'd0;
      start_q_r  <= 1'b0;
      rst_q_r    <= 1'b1;
      score1_r   <= SCORE_ZERO;
      score2_r   <= SCORE_ZERO;
      dir_r      <= 1'b0;
      winner_r   <= 1'b0;
      serve_go_r <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      start_q_r  <= start;
      rst_q_r    <= 1'b0;
      score1_r   <= score1_nx_s;
      score2_r   <= score2_nx_s;
      dir_r      <= dir_nx_s;
      winner_r   <= winner_nx_s;
      serve_go_r <= (state_r == ST_SERVE) && (state_nx_s == ST_PLAY);
      if (state_nx_s != state_r) begin
        cnt_r <= 8'd0;
      end else if (frame_tick && (state_r != ST_PAUSED)) begin
        cnt_r <= cnt_r + 8'd1;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Next-state and next-score decision
  always_comb begin
    state_nx_s  = state_r;
    score1_nx_s = score1_r;
    score2_nx_s = score2_r;
    dir_nx_s    = dir_r;
    winner_nx_s = winner_r;
    case (state_r)
      ST_IDLE: begin
        if (start_re_s) begin
          state_nx_s  = ST_SERVE;
          score1_nx_s = SCORE_ZERO;
          score2_nx_s = SCORE_ZERO;
          dir_nx_s    = 1'b0;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_SERVE: begin
        if (frame_tick && (cnt_r == SERVE_LAST)) begin
          state_nx_s = ST_PLAY;
        end else begin
          state_nx_s = ST_SERVE;
        end
      end
      ST_PLAY: begin
        // miss1 takes priority; a simultaneous miss2 is dropped
        if (miss1) begin
          score2_nx_s = inc2_s;
          dir_nx_s    = 1'b0;
          if (inc2_s == WIN_VAL) begin
            state_nx_s  = ST_OVER;
            winner_nx_s = 1'b1;
          end else begin
            state_nx_s = ST_POINT;
          end
        end else if (miss2) begin
          score1_nx_s = inc1_s;
          dir_nx_s    = 1'b1;
          if (inc1_s == WIN_VAL) begin
            state_nx_s  = ST_OVER;
            winner_nx_s = 1'b0;
          end else begin
            state_nx_s = ST_POINT;
          end
        end else if (pause_re_s) begin
          state_nx_s = ST_PAUSED;
        end else begin
          state_nx_s = ST_PLAY;
        end
      end
      ST_POINT: begin
        if (frame_tick && (cnt_r == POINT_LAST)) begin
          state_nx_s = ST_SERVE;
        end else begin
          state_nx_s = ST_POINT;
        end
      end
      ST_OVER: begin
        if (start_re_s) begin
          state_nx_s  = ST_SERVE;
          score1_nx_s = SCORE_ZERO;
          score2_nx_s = SCORE_ZERO;
          dir_nx_s    = ~winner_r;
        end else begin
          state_nx_s = ST_OVER;
        end
      end
      ST_PAUSED: begin
        if (pause_re_s) begin
          state_nx_s = ST_PLAY;
        end else begin
          state_nx_s = ST_PAUSED;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Movement controls decoded from the registered state
  always_comb begin
    freeze_s    = 1'b1;
    ball_rst_s  = 1'b1;
    game_over_s = 1'b0;
    case (state_r)
      ST_IDLE:   begin freeze_s = 1'b1; ball_rst_s = 1'b1; end
      ST_SERVE:  begin freeze_s = 1'b1; ball_rst_s = 1'b1; end
      ST_PLAY:   begin freeze_s = 1'b0; ball_rst_s = 1'b0; end
      ST_POINT:  begin freeze_s = 1'b1; ball_rst_s = 1'b0; end
      ST_OVER:   begin freeze_s = 1'b1; ball_rst_s = 1'b1; game_over_s = 1'b1; end
      ST_PAUSED: begin freeze_s = 1'b1; ball_rst_s = 1'b0; end
      default:   begin freeze_s = 1'b1; ball_rst_s = 1'b1; end
    endcase
  end

  assign freeze    = freeze_s;
  assign ball_rst  = ball_rst_s;
  assign game_over = game_over_s;
  assign serve_go  = serve_go_r;
  assign serve_dir = dir_r;
  assign score1    = score1_r;
  assign score2    = score2_r;
  assign winner    = winner_r;
  assign state     = state_r;

endmodule
